// File: rtl/mux_rr_stream.sv
// N_CH:1 streaming multiplexer with a one-deep registered output, direct-select and round-robin modes.
// Define MUX_CNT_EN to build the 16-bit accepted-transfer counter and its xfer_cnt port.
module mux_rr_stream #(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MUX_CNT_EN
    ,
    output logic [15:0]           xfer_cnt
`endif
);

    // Handshake: a word moves across any port only in a cycle where its valid and
    // ready are both high at the rising edge; valid never waits on ready.
    logic             load;
    logic             accept;
    logic             gnt_v;
    logic [SEL_W-1:0] gnt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_gnt;
    logic             rr_found;
    logic [WIDTH-1:0] gnt_data;

    assign load   = !out_valid || out_ready;
    assign accept = load && gnt_v;

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        int idx;
        idx      = 0;
        rr_gnt   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_gnt   = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        gnt   = sel;
        gnt_v = 1'b0;
        if (mode) begin
            gnt   = rr_gnt;
            gnt_v = rr_found;
        end else if (int'(sel) < N_CH) begin
            gnt_v = in_valid[sel];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = accept && (int'(gnt) == i);
        end
    end

    assign gnt_data = in_data[int'(gnt)*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SEL_W'(N_CH - 1);
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
            ptr       <= gnt;
        end else if (load) begin
            // Drained with nothing to replace it; data and channel are kept.
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (accept) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Randomised and directed bench for mux_rr_stream, checked against a transaction-level model
// and an end-to-end expected-word queue.
module tb_mux_rr_stream;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
`ifdef MUX_CNT_EN
    logic [15:0]           xfer_cnt;
`endif

    mux_rr_stream #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // scoreboard: words accepted but not yet taken by the consumer, as {ch, data}
    logic [SEL_W+WIDTH-1:0] exp_q[$];

    // reference model state
    bit               m_valid;
    logic [WIDTH-1:0] m_data;
    logic [SEL_W-1:0] m_ch;
    int               m_last;
    int               m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fairness rule: in round-robin the channel granted last goes to the back of the line.
    function automatic int pick(output bit found);
        int order[$];
        found = 1'b0;
        if (!mode) begin
            found = in_valid[sel];
            return int'(sel);
        end
        for (int c = 0; c < N_CH; c++) order.push_back(c);
        while (order[N_CH-1] != m_last) order.push_back(order.pop_front());
        foreach (order[j]) begin
            if (in_valid[order[j]]) begin
                found = 1'b1;
                return order[j];
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = '0;
        m_last  = N_CH - 1;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, "_out_data"}, 32'(out_data), 32'(m_data));
        check({tag, "_out_ch"}, 32'(out_ch), 32'(m_ch));
`ifdef MUX_CNT_EN
        check({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
`endif
    endtask

    // driver: inputs already set after a falling edge; runs one clock cycle
    task automatic step(input string tag);
        bit                     gv;
        int                     g;
        bit                     ld;
        logic [N_CH-1:0]        exp_rdy;
        logic [SEL_W+WIDTH-1:0] exp_w;
        #1;
        g       = pick(gv);
        ld      = !m_valid || out_ready;
        exp_rdy = (ld && gv) ? N_CH'(1 << g) : '0;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 32'(1), 32'(0));
            end else begin
                exp_w = exp_q.pop_front();
                check({tag, "_stream"}, 32'({out_ch, out_data}), 32'(exp_w));
            end
        end
        if (ld && gv) begin
            m_valid = 1'b1;
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_ch    = SEL_W'(g);
            m_last  = g;
            m_cnt   = (m_cnt + 1) % 65536;
            exp_q.push_back({m_ch, m_data});
        end else if (ld) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // direct select of channel 0
        in_valid = 4'b0001;
        set_data(8'hA5, 8'h00, 8'h00, 8'h00);
        step("t1");
        check("t1_data_A5", 32'(out_data), 32'h0000_00A5);

        // direct select of channel 2, every channel valid
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b1111;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 4; i++) step("t2");
        check("t2_data_12", 32'(out_data), 32'h0000_0012);

        // round-robin from a clean reset: 0,1,2,3,0,1
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step("t3");
            check("t3_rr_order", 32'(out_ch), 32'(i % N_CH));
        end

        // sparse round-robin: alternates 1 and 3
        in_valid = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            step("t4");
            check("t4_no_ch0_ch2", 32'(in_ready & 4'b0101), 32'(0));
        end

        // stall, with mode/sel changes while held, then release
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = i[0];
            sel  = SEL_W'(i);
            step("t5_stall");
        end
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step("t5_release");

        // asynchronous reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'(0));
        model_reset();
        check_outputs("t6_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        mode     = 1'b1;
        in_valid = 4'b1111;
        step("t6_first");
        check("t6_first_ch0", 32'(out_ch), 32'(0));

        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = SEL_W'($urandom_range(0, N_CH - 1));
            in_valid  = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            in_data   = {$urandom(), $urandom()};
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
